blit_sequencer: RTL and testbench

Blitter state machine sequencer: takes over the bus, fetches parameters and commands, and steps the source-read, destination-read and write memory cycles for each blit. It also handles collision stop/resume and the software reset pulse. It consumes the command/mode register outputs (RUN, COLST, PARRD, SRCEN, DSTEN, SRCENF) and the RESUME/SRESET pulses produced by the command register block. It drives the bus request, memory-cycle and command-load strobes back into the blitter.

---
 rtl/blit_sequencer.sv | 152 +++++++++++++++
 tb/tb_blit_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/blit_sequencer.sv
// Blitter sequencer: bus takeover, parameter/command fetch and per-pixel memory cycles.
// Optional collision halt/resume is built when BLIT_COLLISION_STOP_EN is defined.
module blit_sequencer #(
    parameter int N_PARAM = 12
) (
    input  logic       CCLK,
    input  logic       RESET,
    input  logic       RUN,
    input  logic       COLST,
    input  logic       PARRD,
    input  logic       SRCEN,
    input  logic       DSTEN,
    input  logic       SRCENF,
    input  logic       RESUME,
    input  logic       SRESET,
    input  logic [8:0] ICNT_IN,
    input  logic [7:0] OCNT_IN,
    input  logic       BGRANT,
    input  logic       MACK,
    input  logic       COLL,
    output logic       BREQ,
    output logic       MREQ,
    output logic [1:0] MTYPE,
    output logic       MDST,
    output logic [3:0] PIDX,
    output logic       LDCMDL,
    output logic       STOP,
    output logic [8:0] ICNT,
    output logic       BUSY
);

    typedef enum logic [3:0] {
        S_IDLE, S_REQ, S_PARAM, S_LOAD, S_SRC, S_DST,
        S_WR, S_STEP, S_CMD, S_CMDCHK, S_HALT
    } state_t;

    localparam logic [3:0] PLAST = 4'(N_PARAM - 1);

    state_t     state;
    state_t     nxt;
    logic [7:0] ocnt;
    logic       resume_flag;
    logic       stop_r;
    logic       coll_hit;
    logic       resume_ok;

`ifdef BLIT_COLLISION_STOP_EN
    assign coll_hit  = COLL && COLST;
    assign resume_ok = RESUME;
    assign STOP      = stop_r;
`else
    logic unused_coll;
    assign unused_coll = ^{COLL, COLST, RESUME, stop_r};
    assign coll_hit    = 1'b0;
    assign resume_ok   = 1'b0;
    assign STOP        = 1'b0;
`endif

    // Inner-loop entry; fol is the first-of-line flag for the upcoming pixel
    function automatic state_t entry(input logic fol, input logic src,
                                     input logic srcf, input logic dst);
        if (src || (srcf && fol))
            return S_SRC;
        else if (dst)
            return S_DST;
        else
            return S_WR;
    endfunction

    function automatic logic [1:0] mtype_of(input state_t s);
        unique case (s)
            S_PARAM:      return 2'd1;
            S_SRC, S_DST: return 2'd2;
            S_WR:         return 2'd3;
            default:      return 2'd0;
        endcase
    endfunction

    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE:   if (RUN) nxt = S_REQ;
            S_REQ:
                if (BGRANT)
                    nxt = resume_flag ? S_WR : (PARRD ? S_PARAM : S_LOAD);
            S_PARAM:  if (MACK && PIDX == PLAST) nxt = S_LOAD;
            S_LOAD:   nxt = entry(1'b1, SRCEN, SRCENF, DSTEN);
            S_SRC:    if (MACK) nxt = DSTEN ? S_DST : S_WR;
            S_DST:    if (MACK) nxt = coll_hit ? S_HALT : S_WR;
            S_WR:     if (MACK) nxt = S_STEP;
            S_STEP:
                if (ICNT == 9'd1)
                    nxt = (ocnt == 8'd1) ? S_CMD
                                         : entry(1'b1, SRCEN, SRCENF, DSTEN);
                else
                    nxt = entry(1'b0, SRCEN, SRCENF, DSTEN);
            S_CMD:    if (MACK) nxt = S_CMDCHK;
            S_CMDCHK: nxt = RUN ? (PARRD ? S_PARAM : S_LOAD) : S_IDLE;
            S_HALT:   if (resume_ok) nxt = S_REQ;
            default:  nxt = S_IDLE;
        endcase
        if (SRESET) nxt = S_IDLE;
    end

    always_ff @(posedge CCLK) begin
        if (RESET || SRESET) begin
            state       <= S_IDLE;
            ocnt        <= 8'd0;
            ICNT        <= 9'd0;
            PIDX        <= 4'd0;
            resume_flag <= 1'b0;
            stop_r      <= 1'b0;
            BREQ        <= 1'b0;
            MREQ        <= 1'b0;
            MTYPE       <= 2'd0;
            MDST        <= 1'b0;
            LDCMDL      <= 1'b1;
            BUSY        <= 1'b0;
        end else begin
            state  <= nxt;
            BREQ   <= (nxt != S_IDLE) && (nxt != S_HALT);
            BUSY   <= (nxt != S_IDLE);
            MREQ   <= (nxt == S_PARAM) || (nxt == S_SRC) || (nxt == S_DST)
                   || (nxt == S_WR) || (nxt == S_CMD);
            MTYPE  <= mtype_of(nxt);
            MDST   <= (nxt == S_DST);
            stop_r <= (nxt == S_HALT);
            LDCMDL <= !((state == S_CMD) && MACK);
            unique case (state)
                S_REQ:
                    if (BGRANT) resume_flag <= 1'b0;
                S_PARAM:
                    if (MACK) PIDX <= (PIDX == PLAST) ? 4'd0 : PIDX + 4'd1;
                S_LOAD: begin
                    ICNT <= ICNT_IN;
                    ocnt <= OCNT_IN;
                end
                S_STEP:
                    if (ICNT == 9'd1) begin
                        ICNT <= ICNT_IN;
                        ocnt <= ocnt - 8'd1;
                    end else begin
                        ICNT <= ICNT - 9'd1;
                    end
                S_HALT:
                    if (resume_ok) resume_flag <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_blit_sequencer.sv
// Directed testbench for blit_sequencer with an immediate-ack memory responder.
module tb_blit_sequencer;

    logic       CCLK = 1'b0;
    logic       RESET, RUN, COLST, PARRD, SRCEN, DSTEN, SRCENF;
    logic       RESUME, SRESET, BGRANT, MACK, COLL;
    logic [8:0] ICNT_IN;
    logic [7:0] OCNT_IN;
    logic       BREQ, MREQ, MDST, LDCMDL, STOP, BUSY;
    logic [1:0] MTYPE;
    logic [3:0] PIDX;
    logic [8:0] ICNT;

    int compared = 0;
    int mismatched = 0;

    int n_par, n_src, n_dst, n_wr, n_cmd, n_ldl, coll_dst;
    bit pidx_ok, saw_stop, first_breq, mreq2;
    int icnt_log[$];
    int src_at_wr[$];

    always #5 CCLK = ~CCLK;

    blit_sequencer #(.N_PARAM(12)) dut (
        .CCLK(CCLK), .RESET(RESET), .RUN(RUN), .COLST(COLST),
        .PARRD(PARRD), .SRCEN(SRCEN), .DSTEN(DSTEN), .SRCENF(SRCENF),
        .RESUME(RESUME), .SRESET(SRESET), .ICNT_IN(ICNT_IN),
        .OCNT_IN(OCNT_IN), .BGRANT(BGRANT), .MACK(MACK), .COLL(COLL),
        .BREQ(BREQ), .MREQ(MREQ), .MTYPE(MTYPE), .MDST(MDST),
        .PIDX(PIDX), .LDCMDL(LDCMDL), .STOP(STOP), .ICNT(ICNT),
        .BUSY(BUSY)
    );

    task automatic clear_log();
        n_par = 0; n_src = 0; n_dst = 0; n_wr = 0; n_cmd = 0; n_ldl = 0;
        coll_dst = 0; pidx_ok = 1; saw_stop = 0;
        icnt_log.delete();
        src_at_wr.delete();
    endtask

    task automatic setup(input logic parrd, input logic src, input logic srcf,
                         input logic dst, input logic colst,
                         input logic [8:0] ic, input logic [7:0] oc);
        PARRD = parrd; SRCEN = src; SRCENF = srcf; DSTEN = dst;
        COLST = colst; ICNT_IN = ic; OCNT_IN = oc;
    endtask

    // Acks every request on the following edge and logs each memory cycle
    task automatic run(input int budget, output int cycles, output bit timeout);
        cycles = 0;
        timeout = 1;
        for (int i = 0; i < budget; i++) begin
            @(negedge CCLK);
            cycles++;
            if (cycles == 1) first_breq = BREQ;
            if (cycles == 2) mreq2 = MREQ;
            RUN = 0;
            MACK = 0;
            COLL = 0;
            if (MREQ) begin
                MACK = 1;
                case (MTYPE)
                    2'd0: n_cmd++;
                    2'd1: begin
                        if (PIDX != 4'(n_par)) pidx_ok = 0;
                        n_par++;
                    end
                    2'd2:
                        if (MDST) begin
                            n_dst++;
                            if (n_dst == coll_dst) COLL = 1;
                        end else begin
                            n_src++;
                            src_at_wr.push_back(n_wr);
                        end
                    default: begin
                        icnt_log.push_back(int'(ICNT));
                        n_wr++;
                    end
                endcase
            end
            if (!LDCMDL) n_ldl++;
            if (STOP) saw_stop = 1;
            if (!BUSY || STOP) begin
                timeout = 0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        RESET = 1;
        repeat (2) @(negedge CCLK);
        compared++; if (BREQ !== 1'b0) begin mismatched++; $display("FAIL reset_breq got %b want 0", BREQ); end
        compared++; if (MREQ !== 1'b0) begin mismatched++; $display("FAIL reset_mreq got %b want 0", MREQ); end
        compared++; if (MTYPE !== 2'd0) begin mismatched++; $display("FAIL reset_mtype got %0d want 0", MTYPE); end
        compared++; if (MDST !== 1'b0) begin mismatched++; $display("FAIL reset_mdst got %b want 0", MDST); end
        compared++; if (PIDX !== 4'd0) begin mismatched++; $display("FAIL reset_pidx got %0d want 0", PIDX); end
        compared++; if (LDCMDL !== 1'b1) begin mismatched++; $display("FAIL reset_ldcmdl got %b want 1", LDCMDL); end
        compared++; if (STOP !== 1'b0) begin mismatched++; $display("FAIL reset_stop got %b want 0", STOP); end
        compared++; if (ICNT !== 9'd0) begin mismatched++; $display("FAIL reset_icnt got %0d want 0", ICNT); end
        compared++; if (BUSY !== 1'b0) begin mismatched++; $display("FAIL reset_busy got %b want 0", BUSY); end
        RESET = 0;
        @(negedge CCLK);
    endtask

    task automatic test_param();
        int cyc;
        bit to;
        clear_log();
        setup(1, 0, 0, 0, 0, 9'd1, 8'd1);
        RUN = 1;
        run(200, cyc, to);
        compared++; if (to) begin mismatched++; $display("FAIL param_timeout got busy after %0d cycles want idle", cyc); end
        compared++; if (first_breq !== 1'b1) begin mismatched++; $display("FAIL param_breq_latency got %b want 1", first_breq); end
        compared++; if (mreq2 !== 1'b1) begin mismatched++; $display("FAIL param_mreq_latency got %b want 1", mreq2); end
        compared++; if (n_par != 12) begin mismatched++; $display("FAIL param_count got %0d want 12", n_par); end
        compared++; if (!pidx_ok) begin mismatched++; $display("FAIL param_pidx_seq got out-of-order want 0..11"); end
        compared++; if (n_cmd != 1 || n_ldl != 1) begin mismatched++; $display("FAIL param_cmd got cmd=%0d ldl=%0d want 1/1", n_cmd, n_ldl); end
        compared++; if (cyc != 19) begin mismatched++; $display("FAIL param_cycles got %0d want 19", cyc); end
        compared++; if (BUSY !== 1'b0) begin mismatched++; $display("FAIL param_busy got %b want 0", BUSY); end
    endtask

    task automatic test_src_dst();
        int cyc;
        bit to;
        int exp_ic[6] = '{3, 2, 1, 3, 2, 1};
        bit ic_ok;
        clear_log();
        setup(0, 1, 0, 1, 0, 9'd3, 8'd2);
        RUN = 1;
        run(200, cyc, to);
        compared++; if (to) begin mismatched++; $display("FAIL srcdst_timeout got busy want idle"); end
        compared++; if (n_src != 6 || n_dst != 6 || n_wr != 6) begin mismatched++; $display("FAIL srcdst_counts got %0d/%0d/%0d want 6/6/6", n_src, n_dst, n_wr); end
        ic_ok = (icnt_log.size() == 6);
        if (ic_ok) for (int i = 0; i < 6; i++) if (icnt_log[i] != exp_ic[i]) ic_ok = 0;
        compared++; if (!ic_ok) begin mismatched++; $display("FAIL srcdst_icnt_trace got %p want 3,2,1,3,2,1", icnt_log); end
        compared++; if (cyc != 29) begin mismatched++; $display("FAIL srcdst_cycles got %0d want 29", cyc); end
        compared++; if (ICNT !== 9'd3) begin mismatched++; $display("FAIL srcdst_icnt_reload got %0d want 3", ICNT); end
    endtask

    task automatic test_sreset();
        bit found = 0;
        clear_log();
        setup(1, 0, 0, 0, 0, 9'd1, 8'd1);
        RUN = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge CCLK);
            RUN = 0;
            MACK = MREQ;
            if (MREQ && MTYPE == 2'd1 && PIDX == 4'd5) begin
                found = 1;
                break;
            end
        end
        compared++; if (!found) begin mismatched++; $display("FAIL sreset_reach got no pidx 5 want pidx 5"); end
        MACK = 1;
        SRESET = 1;
        @(negedge CCLK);
        SRESET = 0;
        MACK = 0;
        compared++; if (BUSY !== 1'b0) begin mismatched++; $display("FAIL sreset_busy got %b want 0", BUSY); end
        compared++; if (PIDX !== 4'd0) begin mismatched++; $display("FAIL sreset_pidx got %0d want 0", PIDX); end
        compared++; if (ICNT !== 9'd0) begin mismatched++; $display("FAIL sreset_icnt got %0d want 0", ICNT); end
        for (int i = 0; i < 5; i++) begin
            @(negedge CCLK);
            if (MREQ || BREQ) saw_stop = 1;
        end
        compared++; if (saw_stop) begin mismatched++; $display("FAIL sreset_quiet got bus activity want none"); end
    endtask

    task automatic test_srcenf();
        int cyc;
        bit to;
        clear_log();
        setup(0, 0, 1, 0, 0, 9'd4, 8'd2);
        RUN = 1;
        run(200, cyc, to);
        compared++; if (to) begin mismatched++; $display("FAIL srcenf_timeout got busy want idle"); end
        compared++; if (n_src != 2 || n_wr != 8) begin mismatched++; $display("FAIL srcenf_counts got src=%0d wr=%0d want 2/8", n_src, n_wr); end
        compared++; if (src_at_wr.size() != 2 || src_at_wr[0] != 0 || src_at_wr[1] != 4) begin mismatched++; $display("FAIL srcenf_position got %p want 0,4", src_at_wr); end
    endtask

    task automatic test_collision();
        int cyc;
        bit to;
        clear_log();
        setup(0, 0, 0, 1, 1, 9'd3, 8'd1);
        coll_dst = 2;
        RUN = 1;
        run(200, cyc, to);
        compared++; if (to) begin mismatched++; $display("FAIL coll_timeout got no stop/idle want one"); end
`ifdef BLIT_COLLISION_STOP_EN
        compared++; if (STOP !== 1'b1 || BREQ !== 1'b0) begin mismatched++; $display("FAIL coll_halt got stop=%b breq=%b want 1/0", STOP, BREQ); end
        compared++; if (n_dst != 2 || n_wr != 1) begin mismatched++; $display("FAIL coll_halt_counts got dst=%0d wr=%0d want 2/1", n_dst, n_wr); end
        RESUME = 1;
        @(negedge CCLK);
        RESUME = 0;
        compared++; if (BREQ !== 1'b1 || STOP !== 1'b0) begin mismatched++; $display("FAIL coll_resume got breq=%b stop=%b want 1/0", BREQ, STOP); end
        run(200, cyc, to);
        compared++; if (to || BUSY !== 1'b0) begin mismatched++; $display("FAIL coll_finish got busy=%b want 0", BUSY); end
        compared++; if (n_dst != 3 || n_wr != 3) begin mismatched++; $display("FAIL coll_resume_counts got dst=%0d wr=%0d want 3/3", n_dst, n_wr); end
        compared++; if (icnt_log.size() != 3 || icnt_log[1] != 2) begin mismatched++; $display("FAIL coll_resume_icnt got %p want 3,2,1", icnt_log); end
`else
        compared++; if (saw_stop || BUSY !== 1'b0) begin mismatched++; $display("FAIL coll_ignored got stop=%b busy=%b want 0/0", saw_stop, BUSY); end
        compared++; if (n_dst != 3 || n_wr != 3) begin mismatched++; $display("FAIL coll_ignored_counts got dst=%0d wr=%0d want 3/3", n_dst, n_wr); end
`endif
    endtask

    task automatic test_icnt_512();
        int cyc;
        bit to;
        clear_log();
        setup(0, 0, 0, 0, 0, 9'd0, 8'd1);
        RUN = 1;
        run(2000, cyc, to);
        compared++; if (to) begin mismatched++; $display("FAIL icnt512_timeout got busy want idle"); end
        compared++; if (n_wr != 512 || n_cmd != 1) begin mismatched++; $display("FAIL icnt512_counts got wr=%0d cmd=%0d want 512/1", n_wr, n_cmd); end
        compared++; if (cyc != 1029) begin mismatched++; $display("FAIL icnt512_cycles got %0d want 1029", cyc); end
        compared++; if (icnt_log.size() != 512 || icnt_log[1] != 511 || icnt_log[511] != 1) begin mismatched++; $display("FAIL icnt512_wrap got size %0d want 0,511..1", icnt_log.size()); end
    endtask

    task automatic test_ocnt_256();
        int cyc;
        bit to;
        clear_log();
        setup(0, 0, 0, 0, 0, 9'd1, 8'd0);
        RUN = 1;
        run(2000, cyc, to);
        compared++; if (to) begin mismatched++; $display("FAIL ocnt256_timeout got busy want idle"); end
        compared++; if (n_wr != 256 || cyc != 517) begin mismatched++; $display("FAIL ocnt256_lines got wr=%0d cyc=%0d want 256/517", n_wr, cyc); end
    endtask

    initial begin
        RESET = 1; RUN = 0; COLST = 0; PARRD = 0; SRCEN = 0; DSTEN = 0;
        SRCENF = 0; RESUME = 0; SRESET = 0; BGRANT = 1; MACK = 0; COLL = 0;
        ICNT_IN = 9'd0; OCNT_IN = 8'd0;
        test_reset();
        test_param();
        test_src_dst();
        test_sreset();
        test_srcenf();
        test_collision();
        test_icnt_512();
        test_ocnt_256();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
